// File: rtl/ofs_serializer_if.sv
// ofs_serializer_if: word handshake between an upstream source and the serializer.
// The source drives a word plus end-of-stream marker; the serializer answers with ready.
interface ofs_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] DIN;
    logic             DLAST;
    logic             DVALID;
    logic             DREADY;

    modport master (output DIN, output DLAST, output DVALID, input DREADY);
    modport slave  (input DIN, input DLAST, input DVALID, output DREADY);
endinterface

// File: rtl/ofs_serializer.sv
// ofs_serializer: parallel-to-serial feeder for an I/O-cell output flip-flop.
// A holding register in front of the shift register gives gap-free streaming.
// At stream end one PARK cycle clocks the idle level into the output flop.
// All outputs come straight from flops; nothing combinational reaches a pin.
module ofs_serializer #(
    parameter int   WIDTH     = 4,
    parameter logic IDLE_VAL  = 1'b0,
    parameter int   MSB_FIRST = 0
) (
    input  logic            SCLK,
    input  logic            RSTN,
    ofs_serializer_if.slave s_word,
    output logic            SDO,
    output logic            SDO_EN,
    output logic            BUSY,
    output logic            UNDERRUN,
    input  logic            CLR_UNDR
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PARK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic             r_sreg_last;
    logic             w_sreg_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_last;
    logic             r_hold_full;
    logic             r_dready;
    logic             r_sdo;
    logic             r_sdo_en;
    logic             r_busy;
    logic             r_underrun;
    logic             w_load;
    logic             w_undr_set;
    logic             w_accept;
    logic             w_hold_full_nxt;

    // Move the shift register on by one bit in the configured order.
    function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) return {v[WIDTH-2:0], 1'b0};
        else                return {1'b0, v[WIDTH-1:1]};
    endfunction

    // Bit that goes on the line next.
    function automatic logic f_head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // DREADY mirrors the next hold occupancy, so it is never high while hold is full.
    assign w_accept        = s_word.DVALID & r_dready;
    assign w_hold_full_nxt = w_accept | (r_hold_full & ~w_load);

    // Next state, shift register and bit counter; reloads from hold take priority.
    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_sreg_last_nxt = r_sreg_last;
        w_cnt_nxt       = r_cnt;
        w_load          = 1'b0;
        w_undr_set      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sreg_nxt = f_advance(r_sreg);
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_hold_full) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = S_PARK;
                    w_undr_set  = ~r_sreg_last;
                end
            end
            S_PARK: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_sreg_nxt      = r_hold;
            w_sreg_last_nxt = r_hold_last;
            w_cnt_nxt       = CNT_LOAD;
        end
    end

    // State, shift register and counter registers.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_sreg_last <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_sreg_last <= w_sreg_last_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Holding register and registered ready; ready stays low until the first edge out of reset.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
            r_dready    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= s_word.DIN;
                r_hold_last <= s_word.DLAST;
            end
            r_hold_full <= w_hold_full_nxt;
            r_dready    <= ~w_hold_full_nxt;
        end
    end

    // Line outputs registered from the next state so they line up with the shift register.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sdo    <= IDLE_VAL;
            r_sdo_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sdo    <= (w_state_nxt == S_SHIFT) ? f_head(w_sreg_nxt) : IDLE_VAL;
            r_sdo_en <= (w_state_nxt != S_IDLE);
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_underrun <= 1'b0;
        end else if (w_undr_set) begin
            r_underrun <= 1'b1;
        end else if (CLR_UNDR) begin
            r_underrun <= 1'b0;
        end
    end

    assign s_word.DREADY = r_dready;
    assign SDO           = r_sdo;
    assign SDO_EN        = r_sdo_en;
    assign BUSY          = r_busy;
    assign UNDERRUN      = r_underrun;

endmodule
